mac_engine: RTL and testbench

Compute stage directly downstream of avalon_interface. On start_calc it reads the pixel and weight memories that avalon_interface fills and runs a 784-input dot product for each of 10 output neurons. Each result is stored in an internal 10-entry result file. The block flags done/overflow; avalon_interface reads results back through output_address/result_output.

---
 rtl/mac_engine_pkg.sv | 38 +++
 rtl/mac_engine_mac_unit.sv | 52 +++++
 rtl/mac_engine.sv | 122 ++++++++++++
 tb/tb_mac_engine.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_engine_pkg.sv
// Shared types and constants for the mac_engine dot-product stage.
// Holds the FSM encoding, sizing constants and the shift/saturate helper.
package mac_engine_pkg;

  localparam int NUM_OUTPUTS = 10;
  localparam int PAIRS       = 392;
  localparam int DATA_W      = 16;
  localparam int PROD_W      = 2 * DATA_W;
  localparam int ACC_W       = 42;
  localparam int SHIFT       = 15;
  localparam int RESULT_W    = 17;
  localparam int RES_MAX     = 65535;
  localparam int RES_MIN     = -65536;

  localparam logic signed [ACC_W-1:0] ACC_RES_MAX = ACC_W'(RES_MAX);
  localparam logic signed [ACC_W-1:0] ACC_RES_MIN = ACC_W'(RES_MIN);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    DRAIN = 3'd2,
    STORE = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Returns {saturated, result}: acc >>> SHIFT clamped to the RESULT_W signed range.
  function automatic logic [RESULT_W:0] sat_shift(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] sh;
    sh = acc >>> SHIFT;
    if (sh > ACC_RES_MAX)
      return {1'b1, RESULT_W'(RES_MAX)};
    else if (sh < ACC_RES_MIN)
      return {1'b1, RESULT_W'(RES_MIN)};
    else
      return {1'b0, sh[RESULT_W-1:0]};
  endfunction

endpackage

// File: rtl/mac_engine_mac_unit.sv
// Two signed multipliers with registered products feeding a wide accumulator.
// Data is taken one cycle after vld_i (memory latency); products land in acc two cycles after that; no backpressure.
module mac_unit
  import mac_engine_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic                       acc_clr_i,
  input  logic                       vld_i,
  input  logic signed [DATA_W-1:0]   pix1_i,
  input  logic signed [DATA_W-1:0]   pix2_i,
  input  logic        [PROD_W-1:0]   weight_i,
  output logic        [RESULT_W-1:0] result_o,
  output logic                       sat_o
);

  logic                     dat_vld_q;
  logic                     prod_vld_q;
  logic signed [PROD_W-1:0] p1_q;
  logic signed [PROD_W-1:0] p2_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [DATA_W-1:0] w1;
  logic signed [DATA_W-1:0] w2;

  assign w1 = weight_i[DATA_W-1:0];
  assign w2 = weight_i[PROD_W-1:DATA_W];

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      dat_vld_q  <= 1'b0;
      prod_vld_q <= 1'b0;
      p1_q       <= '0;
      p2_q       <= '0;
      acc_q      <= '0;
    end else begin
      dat_vld_q  <= vld_i;
      prod_vld_q <= dat_vld_q;
      if (dat_vld_q) begin
        p1_q <= PROD_W'(pix1_i) * PROD_W'(w1);
        p2_q <= PROD_W'(pix2_i) * PROD_W'(w2);
      end
      if (acc_clr_i)
        acc_q <= '0;
      else if (prod_vld_q)
        acc_q <= acc_q + ACC_W'(p1_q) + ACC_W'(p2_q);
    end
  end

  assign {sat_o, result_o} = sat_shift(acc_q);

endmodule

// File: rtl/mac_engine.sv
// Runs 10 neurons x 784-input dot products over external pixel/weight memories, storing saturated results.
// 395 cycles per neuron (392 fetch + 2 drain + 1 store); start is ignored while busy, clear aborts at once.
module mac_engine
  import mac_engine_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start_calc,
  input  logic                clear_data,
  output logic [9:0]          pixel_address1,
  output logic [9:0]          pixel_address2,
  output logic [11:0]         weight_address,
  output logic                mem_read,
  input  logic [DATA_W-1:0]   pixel_data1,
  input  logic [DATA_W-1:0]   pixel_data2,
  input  logic [PROD_W-1:0]   weight_data,
  input  logic [3:0]          output_address,
  output logic [RESULT_W-1:0] result_output,
  output logic                done_calc,
  output logic                overflow,
  output logic                busy
);

  state_t              state_q;
  logic [3:0]          n_q;
  logic [8:0]          k_q;
  logic [11:0]         wbase_q;
  logic                drain_q;
  logic                mem_read_q;
  logic                busy_q;
  logic                done_q;
  logic                ovf_q;
  logic [RESULT_W-1:0] res_q [NUM_OUTPUTS];
  logic [RESULT_W-1:0] mac_res;
  logic                mac_sat;

  mac_unit u_mac (
    .clk       (clk),
    .rst       (rst),
    .flush_i   (clear_data),
    .acc_clr_i (state_q == STORE),
    .vld_i     (mem_read_q),
    .pix1_i    (pixel_data1),
    .pix2_i    (pixel_data2),
    .weight_i  (weight_data),
    .result_o  (mac_res),
    .sat_o     (mac_sat)
  );

  always_ff @(posedge clk) begin
    if (rst || clear_data) begin
      state_q    <= IDLE;
      n_q        <= '0;
      k_q        <= '0;
      wbase_q    <= '0;
      drain_q    <= 1'b0;
      mem_read_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      for (int i = 0; i < NUM_OUTPUTS; i++) res_q[i] <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start_calc) begin
            state_q    <= FETCH;
            n_q        <= '0;
            k_q        <= '0;
            wbase_q    <= '0;
            mem_read_q <= 1'b1;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
          end
        end
        FETCH: begin
          if (k_q == 9'(PAIRS - 1)) begin
            state_q    <= DRAIN;
            k_q        <= '0;
            drain_q    <= 1'b0;
            mem_read_q <= 1'b0;
          end else begin
            k_q <= k_q + 9'd1;
          end
        end
        DRAIN: begin
          if (drain_q) state_q <= STORE;
          drain_q <= 1'b1;
        end
        STORE: begin
          res_q[n_q] <= mac_res;
          if (mac_sat) ovf_q <= 1'b1;
          if (n_q == 4'(NUM_OUTPUTS - 1)) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q    <= FETCH;
            n_q        <= n_q + 4'd1;
            wbase_q    <= wbase_q + 12'(PAIRS);
            mem_read_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Addresses are only meaningful while fetching; they idle at zero.
  assign pixel_address1 = mem_read_q ? {k_q, 1'b0} : '0;
  assign pixel_address2 = mem_read_q ? {k_q, 1'b1} : '0;
  assign weight_address = mem_read_q ? (wbase_q + {3'b000, k_q}) : '0;
  assign mem_read       = mem_read_q;
  assign busy           = busy_q;
  assign done_calc      = done_q;
  assign overflow       = ovf_q;

  always_comb begin
    result_output = '0;
    if (output_address < 4'(NUM_OUTPUTS)) result_output = res_q[output_address];
  end

endmodule

// File: tb/tb_mac_engine.sv
// Self-checking bench for mac_engine: directed plan cases plus randomized memories against an arithmetic model.
module tb_mac_engine;
  import mac_engine_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_calc;
  logic        clear_data;
  logic [9:0]  pixel_address1;
  logic [9:0]  pixel_address2;
  logic [11:0] weight_address;
  logic        mem_read;
  logic [15:0] pixel_data1;
  logic [15:0] pixel_data2;
  logic [31:0] weight_data;
  logic [3:0]  output_address;
  logic [16:0] result_output;
  logic        done_calc;
  logic        overflow;
  logic        busy;

  always #5 clk = ~clk;

  mac_engine dut (
    .clk            (clk),
    .rst            (rst),
    .start_calc     (start_calc),
    .clear_data     (clear_data),
    .pixel_address1 (pixel_address1),
    .pixel_address2 (pixel_address2),
    .weight_address (weight_address),
    .mem_read       (mem_read),
    .pixel_data1    (pixel_data1),
    .pixel_data2    (pixel_data2),
    .weight_data    (weight_data),
    .output_address (output_address),
    .result_output  (result_output),
    .done_calc      (done_calc),
    .overflow       (overflow),
    .busy           (busy)
  );

  logic [15:0] pix [0:783];
  logic [31:0] wgt [0:3919];

  always_ff @(posedge clk) begin
    pixel_data1 <= pix[pixel_address1];
    pixel_data2 <= pix[pixel_address2];
    weight_data <= (weight_address < 12'd3920) ? wgt[weight_address] : 32'h0;
  end

  int          errors = 0;
  int          checks = 0;
  logic [16:0] exp_res [NUM_OUTPUTS];
  bit          exp_ovf;
  logic [9:0]  cap_pa1, cap_pa2;
  logic [11:0] cap_wa;
  logic        cap_mr;
  logic        busy_after_clr;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Plain dot product per neuron, then shift and clamp.
  task automatic model_run();
    for (int n = 0; n < NUM_OUTPUTS; n++) begin
      longint acc = 0;
      longint s;
      for (int k = 0; k < PAIRS; k++) begin
        logic [31:0] w;
        w = wgt[n*PAIRS + k];
        acc += longint'($signed(pix[2*k]))   * longint'($signed(w[15:0]));
        acc += longint'($signed(pix[2*k+1])) * longint'($signed(w[31:16]));
      end
      s = acc >>> 15;
      if (s > 65535) begin s = 65535; exp_ovf = 1'b1; end
      if (s < -65536) begin s = -65536; exp_ovf = 1'b1; end
      exp_res[n] = s[16:0];
    end
  endtask

  task automatic zero_model();
    for (int i = 0; i < NUM_OUTPUTS; i++) exp_res[i] = '0;
    exp_ovf = 1'b0;
  endtask

  task automatic fill_pixels(input logic [15:0] v);
    for (int i = 0; i < 784; i++) pix[i] = v;
  endtask

  task automatic fill_weights_one(input int n, input logic [15:0] w);
    for (int i = 0; i < 3920; i++) wgt[i] = 32'h0;
    for (int k = 0; k < PAIRS; k++) wgt[n*PAIRS + k] = {w, w};
  endtask

  task automatic check_results(input string tag);
    for (int i = 0; i < NUM_OUTPUTS; i++) begin
      @(negedge clk);
      output_address = 4'(i);
      #1;
      check($sformatf("%s_res%0d", tag, i), longint'(result_output), longint'(exp_res[i]));
    end
    check({tag, "_ovf"}, longint'(overflow), longint'(exp_ovf));
  endtask

  task automatic read_result(input int a, output logic [16:0] r);
    @(negedge clk);
    output_address = 4'(a);
    #1;
    r = result_output;
  endtask

  // Pulses start, then watches a fixed 4100-cycle window sampled on negedges.
  task automatic run(input int start_at, input int clr_at, input int addr_at,
                     output int busy_cnt, output bit saw_done);
    @(negedge clk);
    start_calc = 1'b1;
    @(negedge clk);
    start_calc = 1'b0;
    busy_cnt = 0;
    saw_done = 1'b0;
    for (int c = 0; c < 4100; c++) begin
      if (busy) busy_cnt++;
      if (done_calc && (clr_at >= 0 || c < 3950)) saw_done = 1'b1;
      if (c == 3950 && clr_at < 0 && done_calc) saw_done = 1'b1;
      if (c == addr_at) begin
        cap_pa1 = pixel_address1;
        cap_pa2 = pixel_address2;
        cap_wa  = weight_address;
        cap_mr  = mem_read;
      end
      if (c == clr_at + 1) busy_after_clr = busy;
      start_calc = (c == start_at);
      clear_data = (c == clr_at);
      @(negedge clk);
    end
    start_calc = 1'b0;
    clear_data = 1'b0;
  endtask

  int          bc;
  bit          sd;
  logic [16:0] r;

  initial begin
    rst = 1'b1;
    start_calc = 1'b0;
    clear_data = 1'b0;
    output_address = '0;
    fill_pixels(16'h0000);
    fill_weights_one(0, 16'h0000);
    zero_model();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("rst_busy", longint'(busy), 0);
    check("rst_done", longint'(done_calc), 0);
    check("rst_ovf", longint'(overflow), 0);
    check("rst_mem_read", longint'(mem_read), 0);
    check("rst_pa1", longint'(pixel_address1), 0);
    check("rst_pa2", longint'(pixel_address2), 0);
    check("rst_wa", longint'(weight_address), 0);
    read_result(0, r);  check("rst_res0", longint'(r), 0);
    read_result(9, r);  check("rst_res9", longint'(r), 0);
    read_result(15, r); check("rst_res15", longint'(r), 0);

    // Neuron 0 positive, plus the address snapshot at neuron 2, k=5.
    fill_pixels(16'h4000);
    fill_weights_one(0, 16'h0010);
    model_run();
    run(-1, -1, 795, bc, sd);
    check("a_busy_cycles", bc, 3950);
    check("a_done", longint'(sd), 1);
    check("a_done_level", longint'(done_calc), 1);
    check("a_pa1", longint'(cap_pa1), 10);
    check("a_pa2", longint'(cap_pa2), 11);
    check("a_wa", longint'(cap_wa), 789);
    check("a_mr", longint'(cap_mr), 1);
    read_result(0, r);  check("a_res0_const", longint'(r), 6272);
    read_result(12, r); check("a_addr12", longint'(r), 0);
    check_results("a");

    // Neuron 3 negative.
    fill_weights_one(3, 16'hFFF0);
    model_run();
    run(-1, -1, -5, bc, sd);
    check("b_busy_cycles", bc, 3950);
    read_result(3, r);  check("b_res3_const", longint'(r), longint'(17'h1E780));
    check_results("b");

    // Saturation, stickiness across a clean run, then clear.
    fill_weights_one(0, 16'h0100);
    model_run();
    run(-1, -1, -5, bc, sd);
    read_result(0, r);  check("c_res0_sat", longint'(r), 65535);
    check("c_ovf", longint'(overflow), 1);
    fill_weights_one(0, 16'h0010);
    model_run();
    run(-1, -1, -5, bc, sd);
    check("c_ovf_sticky", longint'(overflow), 1);
    check_results("c2");
    @(negedge clk); clear_data = 1'b1;
    @(negedge clk); clear_data = 1'b0;
    zero_model();
    check("c_clr_done", longint'(done_calc), 0);
    check_results("c_clr");

    // Start while busy is ignored.
    model_run();
    run(100, -1, -5, bc, sd);
    check("d_busy_cycles", bc, 3950);
    check("d_done", longint'(sd), 1);
    check_results("d");

    // Abort with clear at cycle 500.
    run(-1, 500, -5, bc, sd);
    zero_model();
    check("e_busy_after_clr", longint'(busy_after_clr), 0);
    check("e_done_never", longint'(sd), 0);
    check("e_busy_end", longint'(busy), 0);
    check_results("e");

    // clear + start together in IDLE stays idle.
    @(negedge clk); clear_data = 1'b1; start_calc = 1'b1;
    @(negedge clk); clear_data = 1'b0; start_calc = 1'b0;
    repeat (3) @(negedge clk);
    check("f_busy", longint'(busy), 0);
    check("f_mem_read", longint'(mem_read), 0);
    check("f_done", longint'(done_calc), 0);

    // Random memories; first run full range (likely saturating), then small ranges.
    for (int rr = 0; rr < 3; rr++) begin
      int plim, wlim;
      plim = (rr == 0) ? 32767 : 4096;
      wlim = (rr == 0) ? 32767 : ((rr == 1) ? 256 : 2048);
      for (int i = 0; i < 784; i++)
        pix[i] = 16'(int'($urandom_range(0, 2*plim)) - plim);
      for (int i = 0; i < 3920; i++) begin
        logic [15:0] lo, hi;
        lo = 16'(int'($urandom_range(0, 2*wlim)) - wlim);
        hi = 16'(int'($urandom_range(0, 2*wlim)) - wlim);
        wgt[i] = {hi, lo};
      end
      model_run();
      run(-1, -1, -5, bc, sd);
      check($sformatf("g%0d_busy_cycles", rr), bc, 3950);
      check($sformatf("g%0d_done", rr), longint'(done_calc), 1);
      check_results($sformatf("g%0d", rr));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
